// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path (byte type, burst
// sequencer states, default queue depth).
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_burst_state_t;

  localparam int TX_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/tx_byte_ring.sv
// Circular byte buffer with push/pop, occupancy count, full/empty flags and a
// flattened oldest-first view of the stored bytes.
module tx_byte_ring
  import uart_pkg::*;
#(
  parameter int DEPTH = TX_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [DEPTH*8-1:0]       peek_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  byte_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic pop_ok;
  logic push_ok;

  // A pop in the same cycle frees the slot a full-buffer push writes into.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
  assign drop_o  = push_i && !push_ok;

  // NOTE: the storage array is reset on purpose: the display reads it through
  // peek_o, and a zeroed buffer keeps that view defined from the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    peek_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) peek_o[i*8 +: 8] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

endmodule

// File: rtl/tx_burst_ctrl.sv
// Byte queue and transmit sequencer feeding uart_tx, single-byte or burst.
// Define TX_GAP_EN to insert GAP_CYCLES idle clocks between burst bytes.
module tx_burst_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH      = TX_DEPTH_DEFAULT,
  parameter int GAP_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [7:0]             push_data_i,
  input  logic                   send_one_i,
  input  logic                   send_all_i,
  input  logic                   tx_done_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic [DEPTH*8-1:0]     peek_o
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("tx_burst_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("tx_burst_ctrl: GAP_CYCLES must be at least 1");
  end

  tx_burst_state_t state_q, state_d;
  logic            burst_q, burst_d;
  byte_t           data_q, data_d;
  logic            done_q;
  logic            overflow_q;
  logic            pop;
  logic            ring_empty;
  logic            ring_drop;
  byte_t           ring_head;

`ifdef TX_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  tx_byte_ring #(.DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .pop_i       (pop),
    .head_o      (ring_head),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (ring_empty),
    .drop_o      (ring_drop),
    .peek_o      (peek_o)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef TX_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Requests see the occupancy before any same-cycle push lands.
        if ((send_one_i || send_all_i) && !ring_empty) begin
          pop     = 1'b1;
          data_d  = ring_head;
          burst_d = send_all_i;
          state_d = LOAD;
        end
      end
      LOAD: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_q) begin
          if (burst_q && !ring_empty) begin
            pop    = 1'b1;
            data_d = ring_head;
`ifdef TX_GAP_EN
            state_d   = GAP;
            gap_cnt_d = GW'(GAP_CYCLES - 1);
`else
            state_d = LOAD;
`endif
          end else begin
            state_d = IDLE;
            burst_d = 1'b0;
          end
        end
      end
`ifdef TX_GAP_EN
      GAP: begin
        if (gap_cnt_q == '0) state_d = LOAD;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      burst_q    <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      data_q     <= data_d;
      done_q     <= tx_done_i;
      overflow_q <= overflow_q | ring_drop;
    end
  end

`ifdef TX_GAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_cnt_q <= '0;
    else        gap_cnt_q <= gap_cnt_d;
  end
`endif

  assign tx_start_o = (state_q == LOAD);
  assign tx_data_o  = data_q;
  assign empty_o    = ring_empty;
  assign busy_o     = (state_q != IDLE);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Scoreboard bench for tx_burst_ctrl: stimulus queues expected bytes, a
// monitor pops them on every tx_start_o pulse, a responder answers uart_tx done.
module tb_tx_burst_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAPC  = 16;
`ifdef TX_GAP_EN
  localparam int LAT = GAPC + 2;
`else
  localparam int LAT = 2;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   push_i;
  logic [7:0]             push_data_i;
  logic                   send_one_i;
  logic                   send_all_i;
  logic                   tx_done_i;
  logic                   tx_start_o;
  logic [7:0]             tx_data_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   busy_o;
  logic                   overflow_o;
  logic [DEPTH*8-1:0]     peek_o;

  tx_burst_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .send_one_i  (send_one_i),
    .send_all_i  (send_all_i),
    .tx_done_i   (tx_done_i),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .peek_o      (peek_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    byte_t data;
    bit    follow;  // burst follower: must start LAT cycles after last done
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors    = 0;
  int   checks    = 0;
  int   n_starts  = 0;
  int   last_done = -1000;
  bit   auto_done = 1'b0;
  int   man_req   = 0;
  int   man_ack   = 0;
  int   timer     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_byte(input byte_t d, input bit f);
    exp_t e;
    e.data   = d;
    e.follow = f;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (tx_done_i) last_done = cyc;
    if (tx_start_o) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_data", 32'(tx_data_o), 32'(mon_e.data));
        if (mon_e.follow) check("burst_latency", 32'(cyc - last_done), 32'(LAT));
      end
    end
  end

  // uart_tx stand-in: manual done on request, or auto done 10 cycles after start
  initial begin
    tx_done_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done_i = 1'b0;
      if (man_req != man_ack) begin
        man_ack   = man_req;
        tx_done_i = 1'b1;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) tx_done_i = 1'b1;
      end
      if (auto_done && tx_start_o) timer = 10;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input byte_t d, input bit s1, input bit sa);
    push_i      = p;
    push_data_i = d;
    send_one_i  = s1;
    send_all_i  = sa;
    step();
    push_i     = 1'b0;
    send_one_i = 1'b0;
    send_all_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy_o) break;
      step();
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_start"},    32'(tx_start_o), 32'd0);
    check({tag, "_data"},     32'(tx_data_o),  32'd0);
    check({tag, "_count"},    32'(count_o),    32'd0);
    check({tag, "_empty"},    32'(empty_o),    32'd1);
    check({tag, "_full"},     32'(full_o),     32'd0);
    check({tag, "_busy"},     32'(busy_o),     32'd0);
    check({tag, "_overflow"}, 32'(overflow_o), 32'd0);
    check({tag, "_peek"},     32'(peek_o),     32'd0);
  endtask

  byte_t burst_bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  byte_t ovf_bytes[5]   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  int    base;

  initial begin
    rst_n       = 1'b0;
    push_i      = 1'b0;
    push_data_i = '0;
    send_one_i  = 1'b0;
    send_all_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;
    step();

    // Single send of the oldest byte, manual done
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    check("t1_count", 32'(count_o), 32'd2);
    check("t1_peek", 32'(peek_o), 32'h0000B2A1);
    expect_byte(8'hA1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_start_next_cycle", 32'(tx_start_o), 32'd1);
    check("t1_count_after", 32'(count_o), 32'd1);
    repeat (4) step();
    man_req++;
    wait_idle(40, "t1_idle");
    repeat (5) step();
    check("t1_pulses", 32'(n_starts), 32'd1);
    check("t1_peek_after", 32'(peek_o), 32'h000000B2);

    // Drain the leftover byte with automatic done
    auto_done = 1'b1;
    expect_byte(8'hB2, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    wait_idle(60, "drain_idle");
    check("drain_empty", 32'(empty_o), 32'd1);

    // Burst of four plus one byte pushed mid-burst
    base = n_starts;
    foreach (burst_bytes[i]) drive(1'b1, burst_bytes[i], 1'b0, 1'b0);
    check("t2_full", 32'(full_o), 32'd1);
    check("t2_peek", 32'(peek_o), 32'h44332211);
    expect_byte(8'h11, 1'b0);
    expect_byte(8'h22, 1'b1);
    expect_byte(8'h33, 1'b1);
    expect_byte(8'h44, 1'b1);
    expect_byte(8'h55, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (4) step();
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    wait_idle(600, "t2_idle");
    check("t2_pulses", 32'(n_starts - base), 32'd5);
    check("t2_empty", 32'(empty_o), 32'd1);
    check("t2_count", 32'(count_o), 32'd0);

    // send_one while empty is ignored
    base = n_starts;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) step();
    check("t4_empty_busy", 32'(busy_o), 32'd0);
    check("t4_empty_pulses", 32'(n_starts - base), 32'd0);

    // Overflow, then push+pop while full
    auto_done = 1'b0;
    foreach (ovf_bytes[i]) drive(1'b1, ovf_bytes[i], 1'b0, 1'b0);
    check("t3_overflow", 32'(overflow_o), 32'd1);
    check("t3_full", 32'(full_o), 32'd1);
    check("t3_count", 32'(count_o), 32'd4);
    check("t3_peek", 32'(peek_o), 32'h04030201);
    expect_byte(8'h01, 1'b0);
    drive(1'b1, 8'h06, 1'b1, 1'b0);
    check("t3_pushpop_count", 32'(count_o), 32'd4);
    check("t3_pushpop_peek", 32'(peek_o), 32'h06040302);
    check("t3_overflow_sticky", 32'(overflow_o), 32'd1);

    // send_one during WAIT_DONE is ignored
    step();
    step();
    base = n_starts;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) step();
    check("t4_busy_count", 32'(count_o), 32'd4);
    check("t4_busy_still", 32'(busy_o), 32'd1);
    man_req++;
    wait_idle(40, "t4_idle");
    repeat (3) step();
    check("t4_busy_pulses", 32'(n_starts - base), 32'd0);
    check("t4_final_count", 32'(count_o), 32'd4);

    // Reset asserted in WAIT_DONE mid-burst
    expect_byte(8'h02, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) step();
    check("t5_busy_before", 32'(busy_o), 32'd1);
    check("t5_count_before", 32'(count_o), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_state("t5");
    step();
    rst_n = 1'b1;
    base  = n_starts;
    man_req++;
    repeat (6) step();
    check("t5_no_pulse", 32'(n_starts - base), 32'd0);
    check("t5_idle", 32'(busy_o), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
